// File: rtl/qam16_pkg.sv
// Shared QAM16 definitions: Gray level codes, default timing/threshold
// constants and the per-rail slicer used by the demapper.
package qam16_pkg;

  typedef enum logic [1:0] {
    LVL_N3 = 2'b00,
    LVL_N1 = 2'b01,
    LVL_P1 = 2'b11,
    LVL_P3 = 2'b10
  } lvl_t;

  localparam int SPS_DEF = 25;
  localparam int SLICE_W = 64;
  localparam logic signed [SLICE_W-1:0] THRESH_DEF = 64'sh2000_0000_0000_0000;

  // Equality at a boundary resolves toward the higher level.
  function automatic lvl_t slice(input logic signed [SLICE_W-1:0] x,
                                 input logic signed [SLICE_W-1:0] thr);
    lvl_t lvl;
    if (x >= thr)       lvl = LVL_P3;
    else if (x >= 0)    lvl = LVL_P1;
    else if (x >= -thr) lvl = LVL_N1;
    else                lvl = LVL_N3;
    return lvl;
  endfunction

endpackage

// File: rtl/qam16_demapper_if.sv
// Sample input / symbol output bundle of the QAM16 demapper.
interface qam16_demapper_if #(
  parameter int DATA_W = 64
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] filter_in_i;
  logic signed [DATA_W-1:0] filter_in_q;
  logic [3:0]               symb;
  logic                     symb_valid;
  logic                     symb_ready;

  modport master (
    output in_valid, filter_in_i, filter_in_q, symb_ready,
    input  symb, symb_valid
  );

  modport slave (
    input  in_valid, filter_in_i, filter_in_q, symb_ready,
    output symb, symb_valid
  );
endinterface

// File: rtl/sym_fifo.sv
// Small synchronous FIFO for decided symbols; extra pointer bit separates
// full from empty. A push into a full FIFO is dropped unless a pop frees space.
module sym_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             drop
);
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/qam16_demapper.sv
// QAM16 hard-decision demapper: picks one sample per symbol, slices I/Q
// against Gray-coded levels and queues the result for the consumer.
module qam16_demapper
  import qam16_pkg::*;
#(
  parameter int                  DATA_W = 64,
  parameter int                  SPS    = SPS_DEF,
  parameter logic signed [63:0]  THRESH = THRESH_DEF,
  localparam int                 CNT_W  = (SPS > 1) ? $clog2(SPS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  qam16_demapper_if.slave  bus,
  input  logic [CNT_W-1:0] phase_sel,
  input  logic             resync,
  output logic             overflow
);
  logic [CNT_W-1:0]         cnt;
  logic                     cap_valid;
  logic signed [DATA_W-1:0] cap_i;
  logic signed [DATA_W-1:0] cap_q;
  logic                     sl_valid;
  logic [3:0]               sl_symb;
  logic                     hit;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     fifo_drop;
  logic                     pop;

  // Out-of-range phase_sel must never match, even though cnt cannot reach it.
  assign hit = bus.in_valid && (cnt == phase_sel) && (int'(phase_sel) < SPS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (resync) begin
      cnt <= '0;
    end else if (bus.in_valid) begin
      cnt <= (cnt == CNT_W'(SPS - 1)) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_i     <= '0;
      cap_q     <= '0;
      sl_valid  <= 1'b0;
      sl_symb   <= '0;
    end else begin
      cap_valid <= hit;
      if (hit) begin
        cap_i <= bus.filter_in_i;
        cap_q <= bus.filter_in_q;
      end
      sl_valid <= cap_valid;
      if (cap_valid) begin
        sl_symb <= {slice(SLICE_W'(cap_i), THRESH), slice(SLICE_W'(cap_q), THRESH)};
      end
    end
  end

  assign pop            = bus.symb_valid && bus.symb_ready;
  assign bus.symb_valid = !fifo_empty;

  sym_fifo #(
    .WIDTH (4),
    .DEPTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sl_valid),
    .din   (sl_symb),
    .pop   (pop),
    .dout  (bus.symb),
    .empty (fifo_empty),
    .full  (fifo_full),
    .drop  (fifo_drop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
  end
endmodule

// File: tb/tb_qam16_demapper.sv
// Directed bench for qam16_demapper: a SPS=1 instance for slicing and FIFO
// corners, a SPS=25 instance for sample selection and resync.
module tb_qam16_demapper;
  localparam logic signed [63:0] T   = 64'sh2000_0000_0000_0000;
  localparam logic signed [63:0] NT1 = -T - 64'sd1;

  typedef struct {
    logic signed [63:0] i;
    logic signed [63:0] q;
    logic [3:0]         exp;
  } vec_t;

  logic clk;
  logic rst1_n, rst2_n;
  logic [0:0] ps1;
  logic [4:0] ps2;
  logic resync1, resync2;
  logic ovf1, ovf2;
  int   errors, checks;
  int   pops2;
  logic [3:0] last2;
  vec_t vecs [8];

  qam16_demapper_if #(.DATA_W(64)) b1 ();
  qam16_demapper_if #(.DATA_W(64)) b2 ();

  qam16_demapper #(.DATA_W(64), .SPS(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(b1), .phase_sel(ps1), .resync(resync1), .overflow(ovf1)
  );
  qam16_demapper #(.DATA_W(64), .SPS(25)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(b2), .phase_sel(ps2), .resync(resync2), .overflow(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (b2.symb_valid && b2.symb_ready) begin
      pops2++;
      last2 = b2.symb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic signed [63:0] i, input logic signed [63:0] q);
    b1.in_valid    = 1'b1;
    b1.filter_in_i = i;
    b1.filter_in_q = q;
    tick();
    b1.in_valid = 1'b0;
  endtask

  task automatic pop1();
    b1.symb_ready = 1'b1;
    tick();
    b1.symb_ready = 1'b0;
  endtask

  task automatic feed2(input int n, input int hit);
    for (int j = 0; j < n; j++) begin
      b2.in_valid    = 1'b1;
      b2.filter_in_i = (j == hit) ? T : NT1;
      b2.filter_in_q = (j == hit) ? T : NT1;
      tick();
      b2.in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic reset2();
    rst2_n = 1'b0;
    tick();
    rst2_n = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0; pops2 = 0; last2 = '0;
    vecs[0] = '{T,                       -T,                       4'b1001};
    vecs[1] = '{-64'sd1,                 64'sd0,                   4'b0111};
    vecs[2] = '{T - 64'sd1,              NT1,                      4'b1100};
    vecs[3] = '{64'sh7fff_ffff_ffff_ffff, 64'sh8000_0000_0000_0000, 4'b1000};
    vecs[4] = '{NT1,                     T,                        4'b0010};
    vecs[5] = '{64'sd1,                  -64'sd1,                  4'b1101};
    vecs[6] = '{64'sd0,                  T + 64'sd5,               4'b1110};
    vecs[7] = '{-T,                      -T,                       4'b0101};

    rst1_n = 1'b0; rst2_n = 1'b0; ps1 = 1'b0; ps2 = 5'd3;
    resync1 = 1'b0; resync2 = 1'b0;
    b1.in_valid = 1'b0; b1.filter_in_i = '0; b1.filter_in_q = '0; b1.symb_ready = 1'b0;
    b2.in_valid = 1'b0; b2.filter_in_i = '0; b2.filter_in_q = '0; b2.symb_ready = 1'b1;
    tick();
    tick();
    rst1_n = 1'b1; rst2_n = 1'b1;

    check("reset_symb_valid", 64'(b1.symb_valid), 64'd0);
    check("reset_symb", 64'(b1.symb), 64'd0);
    check("reset_overflow", 64'(ovf1), 64'd0);

    // Slicing table, one decision at a time with latency check.
    for (int k = 0; k < 8; k++) begin
      drive1(vecs[k].i, vecs[k].q);
      tick();
      check($sformatf("latency_early_%0d", k), 64'(b1.symb_valid), 64'd0);
      tick();
      check($sformatf("slice_%0d", k), 64'({b1.symb_valid, b1.symb}), 64'({1'b1, vecs[k].exp}));
      pop1();
    end

    // phase_sel beyond SPS-1 never decides.
    ps1 = 1'b1;
    for (int k = 0; k < 3; k++) drive1(vecs[k].i, vecs[k].q);
    repeat (3) tick();
    check("phase_out_of_range", 64'(b1.symb_valid), 64'd0);
    ps1 = 1'b0;

    // Push while empty with ready high: no fall-through.
    b1.symb_ready = 1'b1;
    drive1(vecs[2].i, vecs[2].q);
    tick();
    tick();
    check("empty_push_pop", 64'({b1.symb_valid, b1.symb}), 64'({1'b1, vecs[2].exp}));
    tick();
    check("empty_push_pop_drained", 64'(b1.symb_valid), 64'd0);
    b1.symb_ready = 1'b0;

    // Full FIFO with simultaneous push and pop.
    for (int k = 0; k < 5; k++) begin
      b1.in_valid = 1'b1;
      b1.filter_in_i = vecs[k].i;
      b1.filter_in_q = vecs[k].q;
      tick();
    end
    b1.in_valid = 1'b0;
    tick();
    check("full_no_overflow_before", 64'(ovf1), 64'd0);
    pop1();
    check("full_push_pop_overflow", 64'(ovf1), 64'd0);
    for (int k = 1; k < 5; k++) begin
      check($sformatf("full_drain_%0d", k), 64'({b1.symb_valid, b1.symb}), 64'({1'b1, vecs[k].exp}));
      pop1();
    end
    check("full_drain_empty", 64'(b1.symb_valid), 64'd0);

    // Backpressure: six decisions, four kept, overflow sticky.
    for (int k = 0; k < 6; k++) begin
      b1.in_valid = 1'b1;
      b1.filter_in_i = vecs[k].i;
      b1.filter_in_q = vecs[k].q;
      tick();
    end
    b1.in_valid = 1'b0;
    repeat (3) tick();
    check("backpressure_overflow", 64'(ovf1), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("backpressure_out_%0d", k), 64'({b1.symb_valid, b1.symb}), 64'({1'b1, vecs[k].exp}));
      pop1();
    end
    check("backpressure_empty", 64'(b1.symb_valid), 64'd0);
    check("overflow_sticky", 64'(ovf1), 64'd1);

    // Reset with three buffered and one in flight.
    for (int k = 0; k < 4; k++) begin
      b1.in_valid = 1'b1;
      b1.filter_in_i = vecs[k + 4].i;
      b1.filter_in_q = vecs[k + 4].q;
      tick();
    end
    b1.in_valid = 1'b0;
    tick();
    check("midreset_head", 64'({b1.symb_valid, b1.symb}), 64'({1'b1, vecs[4].exp}));
    rst1_n = 1'b0;
    tick();
    rst1_n = 1'b1;
    check("midreset_valid", 64'(b1.symb_valid), 64'd0);
    check("midreset_overflow", 64'(ovf1), 64'd0);
    check("midreset_symb", 64'(b1.symb), 64'd0);
    repeat (3) tick();
    check("midreset_inflight_dropped", 64'(b1.symb_valid), 64'd0);

    // SPS=25: first decision at in_valid index phase_sel, once per symbol.
    reset2();
    ps2 = 5'd3; pops2 = 0; last2 = '0;
    feed2(25, 3);
    repeat (4) tick();
    check("sps25_one_decision", 64'(pops2), 64'd1);
    check("sps25_picked_sample", 64'(last2), 64'hA);

    reset2();
    ps2 = 5'd25; pops2 = 0;
    feed2(30, -1);
    repeat (4) tick();
    check("sps25_phase_out_of_range", 64'(pops2), 64'd0);

    // Resync at counter=10 restarts the count.
    reset2();
    ps2 = 5'd12; pops2 = 0; last2 = '0;
    feed2(10, -1);
    check("resync_none_before", 64'(pops2), 64'd0);
    resync2 = 1'b1;
    tick();
    resync2 = 1'b0;
    feed2(16, 12);
    repeat (4) tick();
    check("resync_one_decision", 64'(pops2), 64'd1);
    check("resync_picked_sample", 64'(last2), 64'hA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qam16_demapper.md
QAM16_DEMAPPER -- requirements
Module: qam16_demapper

Interface
REQ-001 Parameter DATA_W, default 64: signed width of filtered I/Q input samples.
REQ-002 Parameter SPS, default 25: clock-enabled samples per symbol.
REQ-003 Parameter THRESH, default 64'sh2000_0000_0000_0000: outer decision threshold; inner threshold is zero.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  filter_in_i/q carry a new sample this cycle.
REQ-007 filter_in_i  input  DATA_W  signed in-phase filter output.
REQ-008 filter_in_q  input  DATA_W  signed quadrature filter output.
REQ-009 phase_sel  input  log2(SPS) bits  sample index within a symbol at which to decide.
REQ-010 resync  input  1  one-cycle pulse; forces the sample counter to 0.
REQ-011 symb  output  4  recovered symbol; [3:2] from I, [1:0] from Q.
REQ-012 symb_valid  output  1  symb holds a symbol not yet accepted.
REQ-013 symb_ready  input  1  consumer accepts symb when symb_valid && symb_ready.
REQ-014 overflow  output  1  sticky; a decided symbol was dropped because the FIFO was full.

Function
REQ-015 The sample counter shall increment on each in_valid and wrap from SPS-1 to 0.
REQ-016 resync shall set the counter to 0 the following cycle and take priority over the increment.
REQ-017 When in_valid is high and counter == phase_sel, the I/Q pair shall be captured in the decision register (stage 1).
REQ-018 phase_sel >= SPS shall never match; no decisions are made.
REQ-019 Stage 2 shall slice each rail independently, using signed compares: x < -THRESH -> 2'b00; -THRESH <= x < 0 -> 2'b01; 0 <= x < THRESH -> 2'b11; x >= THRESH -> 2'b10 (inverse of the Gray mapping used by constellation_map).
REQ-020 Equality at a threshold shall resolve toward the higher level, as in REQ-019.
REQ-021 Stage 2 shall write the 4-bit symbol into a 4-deep FIFO; the capture-to-FIFO-write latency is 2 cycles.
REQ-022 symb/symb_valid shall present the FIFO head; symb_valid = FIFO not empty.
REQ-023 A pop occurs on symb_valid && symb_ready.
REQ-024 Simultaneous push and pop when full: both shall occur with no overflow; occupancy is unchanged.
REQ-025 Simultaneous push and pop when empty: the push shall succeed and symb_valid shall rise the next cycle (no fall-through).
REQ-026 Push when full without a pop: the symbol shall be discarded, FIFO contents kept, and overflow set until reset.
REQ-027 Pointers shall be 2 bits with an extra wrap bit for full/empty detection.

Reset
REQ-028 With rst_n low at a clk edge: counter=0, pipeline valid flags=0, FIFO pointers=0, symb=4'b0000, symb_valid=0, overflow=0.
REQ-029 Reset asserted mid-operation shall discard all in-flight and buffered symbols with no partial output.
REQ-030 The first decision after reset release occurs at the phase_sel-th in_valid.

Structure
REQ-031 Shared package qam16_pkg holds: the Gray level codes (LVL_N3=2'b00, LVL_N1=2'b01, LVL_P1=2'b11, LVL_P3=2'b10), the default THRESH, and SPS; constellation_map and qam16_demapper both use it.
REQ-032 FIFO sub-module sym_fifo (width 4, depth 4, synchronous).
REQ-033 Slicer is a function in qam16_pkg, not a module.

Verification
REQ-034 Loopback: constellation_map -> two filter instances -> demapper, symbols 0..15 each held 25 clocks, phase_sel tuned to the filter group delay, symb_ready=1 -> symb sequence 0..15 in order, overflow=0.
REQ-035 Threshold edges (direct drive, phase_sel=0, SPS=1): I=THRESH, Q=-THRESH -> symb=4'b1001; I=-1, Q=0 -> 4'b0111.
REQ-036 Backpressure: symb_ready=0 for 6 decisions -> 4 stored, overflow=1; then symb_ready=1 -> the first 4 symbols appear in order.
REQ-037 Full with simultaneous push/pop -> occupancy stays 4, overflow stays 0.
REQ-038 resync pulse at counter=10 -> next decision 1+phase_sel in_valids later.
REQ-039 rst_n low for 1 cycle with 3 symbols buffered -> symb_valid=0 and overflow=0 on the next cycle.
